// File: rtl/eval_sched.sv
// Shared down-counter scheduler: NREQ requesters take turns owning one WIDTH-bit tick counter.
// Define EVAL_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module eval_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StLoad, StCount, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    w_pick;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_len [NREQ];
    logic [WIDTH-1:0] w_len_sel;
    logic             w_owner_req;

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign w_len[g] = len[g*WIDTH +: WIDTH];
    end

    assign w_len_sel   = w_len[r_owner];
    assign w_owner_req = req[r_owner];

`ifdef EVAL_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w_pick = IW'(i);
        end
    end
`else
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW-1:0] r_ptr;

    // Scan starts at the slot after the last completed owner and wraps.
    always_comb begin : p_pick
        logic        found;
        logic [IW:0] sum;
        found  = 1'b0;
        sum    = '0;
        w_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, r_ptr} + (IW+1)'(i);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (!found && req[sum[IW-1:0]]) begin
                w_pick = sum[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Only a completed wait moves the pointer; aborts leave it alone.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == StDone) begin
            r_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
        end
    end
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (|req) w_state_next = StLoad;
            StLoad: begin
                if (!w_owner_req)           w_state_next = StIdle;
                else if (w_len_sel == '0)   w_state_next = StDone;
                else                        w_state_next = StCount;
            end
            StCount: begin
                if (!w_owner_req)                        w_state_next = StIdle;
                else if (tick && r_cnt == WIDTH'(1))     w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle:  if (|req) r_owner <= w_pick;
                StLoad:  r_cnt <= w_len_sel;
                StCount: if (tick && r_cnt != '0) r_cnt <= r_cnt - WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != StIdle);
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = busy && (r_owner == IW'(i));
            done[i]  = (r_state == StDone) && (r_owner == IW'(i));
        end
    end

endmodule

// File: doc/eval_sched.md
EVAL_SCHED -- requirements
Module: eval_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 16: wait-length and counter width in ticks.
REQ-003 Port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port tick  input  1  count strobe, one clk_in cycle wide, normally the output of a delay counter.
REQ-006 Port req  input  NREQ  per-requester wait request; level; held high until that requester's done pulse.
REQ-007 Port len  input  NREQ*WIDTH  per-requester wait length in ticks; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port grant  output  NREQ  one-hot owner of the shared counter; all zero when no owner.
REQ-009 Port done  output  NREQ  one-cycle pulse to the owner when its wait expires.
REQ-010 Port busy  output  1  high in every state except IDLE.

Function
REQ-011 Block SHALL share one WIDTH-bit down-counter among NREQ requesters through a state machine with states IDLE, LOAD, COUNT and DONE.
REQ-012 IDLE: with any req bit high, SHALL select a requester per REQ-019 and go to LOAD on the next edge; otherwise SHALL stay in IDLE.
REQ-013 LOAD: grant SHALL be one-hot on the selected requester; counter SHALL capture that requester's len; next state SHALL be DONE if the captured len is 0, else COUNT.
REQ-014 Later changes to len after the LOAD capture SHALL be ignored.
REQ-015 COUNT: on each cycle with tick high the counter SHALL decrement by 1; on tick with counter equal to 1 the next state SHALL be DONE.
REQ-016 A wait of length L SHALL reach DONE in the cycle after the L-th tick seen in COUNT; ticks seen during IDLE and LOAD SHALL not count.
REQ-017 DONE: done[owner] SHALL be 1 for exactly this cycle, grant SHALL remain asserted, and next state SHALL be IDLE.
REQ-018 Abort: if req[owner] goes low during LOAD or COUNT, the block SHALL go to IDLE on the next edge with no done pulse and SHALL clear grant.
REQ-019 Selection SHALL be round-robin: search starts at the index after the last requester that reached DONE (initially 0), wrapping NREQ-1 to 0.
REQ-020 An aborted requester SHALL not advance the round-robin pointer.
REQ-021 A requester whose req is still high in the IDLE cycle after its DONE is treated as a new request and is subject to round-robin order.
REQ-022 The counter SHALL not wrap: it never decrements below 0.
REQ-023 done and grant SHALL be driven combinationally from registered state only, with no combinational path from inputs.

Reset
REQ-024 While reset is high: state = IDLE, counter = 0, round-robin pointer = 0, grant = 0, done = 0, busy = 0.
REQ-025 Reset asserted mid-wait SHALL abandon the wait immediately, with no done pulse; the first request after release SHALL be served from index 0.

Configuration
REQ-026 Macro EVAL_SCHED_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be absent; when undefined, REQ-019 and REQ-020 apply.

Verification
REQ-027 req=0001, len0=3, tick every 4th cycle -> grant=0001 in LOAD, done[0] in the cycle after the 3rd counted tick, then busy=0.
REQ-028 req0=1 with len0=0 -> LOAD then DONE in consecutive cycles with no tick needed, and done[0] pulses once.
REQ-029 req=1111 held, each len=1 -> done order 0,1,2,3,0 (round-robin); with EVAL_SCHED_FIXED_PRIO_EN defined -> done order 0,0,0,...
REQ-030 req1 dropped after 2 of 5 ticks -> no done[1], IDLE next cycle, and the pointer is unchanged, so the next grant is still computed from the prior owner.
REQ-031 reset pulsed during COUNT with counter=7 -> all outputs 0 asynchronously, and after release req=1010 grants requester 1 first.
REQ-032 len0 changed from 5 to 2 during COUNT -> done[0] still occurs after 5 ticks.
